// File: rtl/act_pkg.sv
// Shared definitions for the activation deserializer and the FC layers that consume its vectors.
package act_pkg;

  localparam int unsigned ACT_WIDTH = 8;
  localparam int unsigned ACT_IN    = 128;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    HOLD
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_w(ACT_IN);

endpackage

// File: rtl/act_deserializer.sv
// Serial-to-parallel activation collector: fills an IN-entry vector beat by beat,
// zero-pads short frames, and holds the vector under a valid/ready handshake.
module act_deserializer
  import act_pkg::*;
#(
  parameter int unsigned WIDTH = ACT_WIDTH,
  parameter int unsigned IN    = ACT_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data [0:IN-1],
  output logic             frame_err
);

  localparam int unsigned   IW   = idx_w(IN);
  localparam logic [IW-1:0] LAST = IW'(IN - 1);

  state_t           state, state_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic             err_nx;
  logic             s_ready_q;
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;
  logic [IN-1:0]    wr_sel;

  assign s_ready = s_ready_q;
  assign m_valid = (state == HOLD);
  assign wr_sel  = wr_en ? (IN'(1) << idx) : '0;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    err_nx   = 1'b0;
    wr_en    = 1'b0;
    wr_val   = '0;
    case (state)
      FILL: begin
        if (s_valid && s_ready) begin
          wr_en  = 1'b1;
          wr_val = s_data;
          // idx saturates at the last slot so it never leaves the FILL/PAD range
          if (idx == LAST) begin
            state_nx = HOLD;
            err_nx   = !s_last;
          end else begin
            idx_nx = idx + 1'b1;
            if (s_last) begin
              err_nx   = 1'b1;
              state_nx = PAD;
            end
          end
        end
      end
      PAD: begin
        wr_en = 1'b1;
        if (idx == LAST) state_nx = HOLD;
        else             idx_nx   = idx + 1'b1;
      end
      HOLD: begin
        if (m_ready) begin
          idx_nx   = '0;
          state_nx = FILL;
        end
      end
      default: begin
        idx_nx   = '0;
        state_nx = FILL;
      end
    endcase
  end

  // s_ready is a register of the next state, so it never depends combinationally on m_ready/s_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      s_ready_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      s_ready_q <= (state_nx == FILL);
      frame_err <= err_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < IN; i++) m_data[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < IN; i++) begin
        if (wr_sel[i]) m_data[i] <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_act_deserializer.sv
// Directed bench for act_deserializer: drives and samples on the falling edge.
module tb_act_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data [0:127];
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int hs_cnt = 0;
  logic [7:0] exp_v [0:127];

  act_deserializer #(.WIDTH(8), .IN(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;
  always @(posedge clk) if (rst_n && m_valid === 1'b1 && m_ready === 1'b1) hs_cnt++;

  function automatic logic [7:0] pat(input int f, input int k);
    return 8'(f * 53 + k * 7 + 1);
  endfunction

  // Called on a falling edge; returns on the falling edge after the beat is accepted.
  task automatic put_beat(input logic [7:0] d, input logic last);
    bit ok;
    ok = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int c = 0; c < 400 && !ok; c++) begin
      if (s_ready === 1'b1) ok = 1;
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL beat_timeout: s_ready=%b, required 1 within 400 cycles", s_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || frame_err !== 1'b0 ||
        m_data[0] !== 8'h00 || m_data[127] !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b frame_err=%b d0=%h d127=%h, required 0 0 0 00 00",
               s_ready, m_valid, frame_err, m_data[0], m_data[127]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: s_ready=%b m_valid=%b, required 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_full_frame;
    int e0, bad;
    e0 = err_cnt; bad = 0;
    m_ready = 1'b1;
    for (int k = 0; k < 128; k++) begin
      exp_v[k] = 8'(k + 1);
      put_beat(8'(k + 1), k == 127);
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_latency: m_valid=%b s_ready=%b, required 1 0", m_valid, s_ready);
    end
    checks++;
    if (m_data[0] !== 8'd1 || m_data[127] !== 8'd128) begin
      failures++;
      $display("FAIL full_ends: d0=%0d d127=%0d, required 1 128", m_data[0], m_data[127]);
    end
    for (int k = 0; k < 128; k++) if (m_data[k] !== exp_v[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_vector: %0d entries wrong, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_release: m_valid=%b s_ready=%b, required 0 1", m_valid, s_ready);
    end
    checks++;
    if (err_cnt - e0 != 0) begin
      failures++;
      $display("FAIL full_no_err: frame_err pulses=%0d, required 0", err_cnt - e0);
    end
  endtask

  task automatic test_backpressure;
    int h0, bad, bad_hold;
    bad = 0; bad_hold = 0;
    m_ready = 1'b0;
    for (int k = 0; k < 128; k++) begin
      exp_v[k] = 8'(255 - k);
      put_beat(8'(255 - k), k == 127);
    end
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1;
    h0 = hs_cnt;
    for (int c = 0; c < 20; c++) begin
      if (m_valid !== 1'b1 || s_ready !== 1'b0) bad_hold++;
      @(negedge clk);
    end
    checks++;
    if (bad_hold != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d cycles with m_valid!=1 or s_ready!=0, required 0", bad_hold);
    end
    for (int k = 0; k < 128; k++) if (m_data[k] !== exp_v[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_data_stable: %0d entries changed, required 0", bad);
    end
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (hs_cnt - h0 != 1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_one_handshake: handshakes=%0d m_valid=%b, required 1 0", hs_cnt - h0, m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_short_frame;
    int e0, pad, bad;
    e0 = err_cnt; pad = 0; bad = 0;
    m_ready = 1'b0;
    for (int k = 0; k < 128; k++) exp_v[k] = 8'h00;
    for (int k = 0; k < 5; k++) begin
      exp_v[k] = 8'(8'hA1 + k);
      put_beat(8'(8'hA1 + k), k == 4);
    end
    s_valid = 1'b0; s_last = 1'b0;
    while (m_valid !== 1'b1 && pad < 300) begin
      pad++;
      @(negedge clk);
    end
    checks++;
    if (pad != 123) begin
      failures++;
      $display("FAIL short_pad_len: pad cycles=%0d, required 123", pad);
    end
    checks++;
    if (err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL short_err: frame_err pulses=%0d, required 1", err_cnt - e0);
    end
    for (int k = 0; k < 128; k++) if (m_data[k] !== exp_v[k]) bad++;
    checks++;
    if (bad != 0 || m_data[4] !== 8'hA5 || m_data[5] !== 8'h00) begin
      failures++;
      $display("FAIL short_vector: %0d wrong, d4=%h d5=%h, required 0 wrong a5 00", bad, m_data[4], m_data[5]);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_missing_last;
    int e0, bad;
    e0 = err_cnt; bad = 0;
    m_ready = 1'b0;
    for (int k = 0; k < 128; k++) begin
      exp_v[k] = pat(99, k);
      put_beat(pat(99, k), 1'b0);
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL missing_last: m_valid=%b pulses=%0d, required 1 1", m_valid, err_cnt - e0);
    end
    for (int k = 0; k < 128; k++) if (m_data[k] !== exp_v[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL missing_last_vector: %0d entries wrong, required 0", bad);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_bursty;
    int sb, tf, rf, cyc, e0, bad;
    sb = 0; tf = 0; rf = 0; cyc = 0; e0 = err_cnt;
    while (rf < 10 && cyc < 20000) begin
      s_valid = (tf < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_data  = pat(tf, sb);
      s_last  = (sb == 127);
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid === 1'b1 && m_ready) begin
        bad = 0;
        for (int k = 0; k < 128; k++) if (m_data[k] !== pat(rf, k)) bad++;
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL bursty_frame%0d: %0d entries wrong, required 0", rf, bad);
        end
        rf++;
      end
      if (s_valid && s_ready === 1'b1) begin
        sb++;
        if (sb == 128) begin sb = 0; tf++; end
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    checks++;
    if (rf != 10 || err_cnt - e0 != 0) begin
      failures++;
      $display("FAIL bursty_count: frames=%0d err_pulses=%0d, required 10 0", rf, err_cnt - e0);
    end
  endtask

  task automatic test_mid_reset;
    int h0, bad;
    bad = 0;
    m_ready = 1'b0;
    for (int k = 0; k < 60; k++) put_beat(8'hEE, 1'b0);
    s_valid = 1'b0;
    h0 = hs_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || frame_err !== 1'b0 ||
        m_data[0] !== 8'h00 || m_data[59] !== 8'h00) begin
      failures++;
      $display("FAIL midreset_zero: m_valid=%b s_ready=%b err=%b d0=%h d59=%h, required 0 0 0 00 00",
               m_valid, s_ready, frame_err, m_data[0], m_data[59]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 128; k++) begin
      exp_v[k] = 8'(k * 3 + 7);
      put_beat(8'(k * 3 + 7), k == 127);
    end
    s_valid = 1'b0; s_last = 1'b0;
    for (int k = 0; k < 128; k++) if (m_data[k] !== exp_v[k]) bad++;
    checks++;
    if (m_valid !== 1'b1 || m_data[0] !== 8'd7 || bad != 0) begin
      failures++;
      $display("FAIL midreset_fresh: m_valid=%b d0=%0d wrong=%0d, required 1 7 0", m_valid, m_data[0], bad);
    end
    @(negedge clk);
    checks++;
    if (hs_cnt - h0 != 1) begin
      failures++;
      $display("FAIL midreset_handshakes: %0d, required 1", hs_cnt - h0);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_missing_last();
    test_bursty();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/act_deserializer.md
Name: act_deserializer

Overview:
- Collects a serial stream of WIDTH-bit activations, one per handshake, into the IN-entry parallel vector that a fully-connected layer neuron consumes.
- Presents the assembled vector with a valid/ready handshake and holds it stable until the consumer accepts it.
- Short frames are zero-padded; malformed framing is flagged and never stalls the stream.
- Sits between the upstream feature-map / previous-layer stream and the combinational FC layer.

Parameters:
- WIDTH, 8, activation bit width (matches the layer's x element width).
- IN, 128, vector length (number of layer inputs).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  block can accept a beat.
- s_data  input  WIDTH  activation value; treated as raw bits, no arithmetic.
- s_last  input  1  marks the final beat of a frame.
- m_valid  output  1  assembled vector is valid.
- m_ready  input  1  consumer accepts the vector.
- m_data  output  WIDTH x [0:IN-1]  unpacked vector; m_data[i] is the i-th accepted beat.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async, rst_n=0): state=FILL, idx=0, every m_data entry=0, m_valid=0, frame_err=0. s_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Reset mid-operation discards any partial or held frame; no output handshake occurs.
- State FILL:
  - s_ready=1, m_valid=0.
  - On s_valid&&s_ready: m_data[idx]<=s_data, idx<=idx+1.
  - If idx==IN-1 on the beat: go to HOLD. frame_err pulses next cycle if s_last=0 (missing last).
  - Else if s_last=1 (short frame, idx<IN-1): frame_err pulses next cycle; go to PAD with idx<=idx+1.
- State PAD:
  - s_ready=0, m_valid=0.
  - Each cycle m_data[idx]<=0, idx<=idx+1; at idx==IN-1 go to HOLD.
  - A frame of n beats (n<IN) spends IN-n cycles in PAD.
- State HOLD:
  - s_ready=0, m_valid=1, m_data stable.
  - On m_ready: idx<=0, go to FILL. s_ready rises the following cycle (one bubble per frame; no same-cycle pass-through).
- Latency: last accepted beat at edge t gives m_valid=1 in the cycle after t (full frame).
- m_data is never cleared on leaving HOLD; stale entries are overwritten by the next frame or by PAD.
- Valid/ready rules:
  - m_valid never deasserts without m_ready.
  - s_ready is registered from state only, with no combinational path from m_ready or s_valid.
  - s_data and s_last are sampled only when s_valid&&s_ready.
- idx is a $clog2(IN)-bit counter and never wraps outside the FILL/PAD bound.
- frame_err is a one-cycle pulse registered on the error edge; it is independent of m_ready.

Decomposition:
- Shared package act_pkg holds:
  - state enum {FILL, PAD, HOLD}.
  - localparam IDX_W=$clog2(IN) helper function.
  - Default WIDTH/IN constants, also used by layer instantiation.
- Single module, no sub-module. The storage array is written through a one-hot decode of idx.

Test Plan:
- Full frame: reset, stream 128 beats data=i+1 (i=0..127), s_last on beat 127, m_ready=1 -> m_valid rises the cycle after beat 127; m_data[0]=1 and m_data[127]=128; frame_err never asserts; s_ready returns 1 two cycles after the last beat.
- Backpressure: full frame, m_ready=0 for 20 cycles -> m_valid held 1, m_data unchanged, s_ready=0 throughout, s_valid beats not accepted; m_ready=1 gives exactly one handshake.
- Short frame: 5 beats 0xA1..0xA5 with s_last on beat 5 -> frame_err pulses once; PAD lasts 123 cycles; m_data[0..4]=A1..A5, m_data[5..127]=0 even if the previous frame left nonzero data.
- Missing last: 128 beats with s_last=0 -> frame_err pulses once; frame delivered normally with m_valid=1.
- Bursty input: s_valid random 50%, m_ready random 50%, 10 frames -> scoreboard matches every vector in order; no beat lost or duplicated.
- Mid-frame reset: assert rst_n=0 after beat 60 -> outputs zero immediately; after release a fresh 128-beat frame delivers only the new data (m_data[0] equals the first new beat).
